// File: rtl/sparse_bitmap_serdes_if.sv
// ---------------------------------------------------------------------------
// sparse_bitmap_serdes_if
// Command, address-drain and bitstream signals of one sparse_bitmap_serdes.
//   op_valid/op_ready/op/addr_in : command request and handshake
//   addr_out/addr_valid/addr_ready : drained address stream
//   tx_data/rx_data               : LANES-wide framed bitstream
//   busy/done                     : status
// master = the user of the block, slave = the block itself.
// ---------------------------------------------------------------------------
interface sparse_bitmap_serdes_if #(
   parameter int SIZE  = 16,
   parameter int LANES = 2
);
   localparam int ADDR_W = $clog2(SIZE);

   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op;
   logic [ADDR_W-1:0] addr_in;
   logic [ADDR_W-1:0] addr_out;
   logic              addr_valid;
   logic              addr_ready;
   logic [LANES-1:0]  tx_data;
   logic [LANES-1:0]  rx_data;
   logic              busy;
   logic              done;

   modport master (
      output op_valid, op, addr_in, addr_ready, rx_data,
      input  op_ready, addr_out, addr_valid, tx_data, busy, done
   );

   modport slave (
      input  op_valid, op, addr_in, addr_ready, rx_data,
      output op_ready, addr_out, addr_valid, tx_data, busy, done
   );
endinterface

// File: rtl/sparse_bitmap_serdes.sv
// ---------------------------------------------------------------------------
// sparse_bitmap_serdes
// Holds a SIZE-bit occupancy bitmap of event addresses. The bitmap can be
// filled address by address, sent as a framed LANES-wide bitstream (one
// header beat with lane0=1, then SIZE/LANES data beats), loaded from such a
// frame, or drained back to addresses in ascending order.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   enable : clock enable; when low nothing changes and no handshake completes
//   bus    : sparse_bitmap_serdes_if.slave (command, drain, bitstream, status)
// ---------------------------------------------------------------------------
module sparse_bitmap_serdes #(
   parameter int SIZE  = 16,
   parameter int LANES = 2
) (
   input logic                   clk,
   input logic                   reset,
   input logic                   enable,
   sparse_bitmap_serdes_if.slave bus
);
   localparam int ADDR_W = $clog2(SIZE);
   localparam int BEATS  = SIZE / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TX_HDR  = 3'd1;
   localparam logic [2:0] S_TX_DATA = 3'd2;
   localparam logic [2:0] S_RX_WAIT = 3'd3;
   localparam logic [2:0] S_RX_DATA = 3'd4;
   localparam logic [2:0] S_DRAIN   = 3'd5;

   localparam logic [2:0] OP_SET      = 3'd1;
   localparam logic [2:0] OP_CLEAR    = 3'd2;
   localparam logic [2:0] OP_TRANSMIT = 3'd3;
   localparam logic [2:0] OP_RECEIVE  = 3'd4;
   localparam logic [2:0] OP_DRAIN    = 3'd5;

   logic [2:0]        state;
   logic [SIZE-1:0]   bitmap;
   logic [BEAT_W-1:0] beat;
   logic [LANES-1:0]  tx_q;
   logic              done_q;
   logic [ADDR_W-1:0] low_idx;
   logic [SIZE-1:0]   low_hot;
   logic              last_beat;
   logic              accept;
   logic              pop;

   // Lowest set bit: scanning downward lets the last hit (lowest index) win.
   always_comb begin
      low_idx = '0;
      low_hot = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (bitmap[i]) begin
            low_idx    = ADDR_W'(i);
            low_hot    = '0;
            low_hot[i] = 1'b1;
         end
      end
   end

   assign last_beat      = (beat == BEAT_W'(BEATS - 1));
   assign bus.op_ready   = (state == S_IDLE) && enable;
   assign accept         = bus.op_valid && bus.op_ready;
   assign bus.addr_valid = (state == S_DRAIN) && (bitmap != '0);
   assign bus.addr_out   = bus.addr_valid ? low_idx : '0;
   assign pop            = bus.addr_valid && bus.addr_ready && enable;
   assign bus.tx_data    = tx_q;
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         bitmap <= '0;
         beat   <= '0;
         tx_q   <= '0;
         done_q <= 1'b0;
      end else if (enable) begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (bus.op)
                     OP_SET: begin
                        bitmap[bus.addr_in] <= 1'b1;
                        done_q              <= 1'b1;
                     end
                     OP_CLEAR: begin
                        bitmap <= '0;
                        done_q <= 1'b1;
                     end
                     OP_TRANSMIT: begin
                        state <= S_TX_HDR;
                        tx_q  <= LANES'(1);
                     end
                     OP_RECEIVE: state <= S_RX_WAIT;
                     OP_DRAIN: begin
                        // An empty bitmap finishes immediately without
                        // ever raising addr_valid.
                        if (bitmap == '0) done_q <= 1'b1;
                        else              state  <= S_DRAIN;
                     end
                     default: ;
                  endcase
               end
            end
            S_TX_HDR: begin
               state <= S_TX_DATA;
               beat  <= '0;
               tx_q  <= bitmap[0 +: LANES];
            end
            S_TX_DATA: begin
               if (last_beat) begin
                  state  <= S_IDLE;
                  tx_q   <= '0;
                  done_q <= 1'b1;
               end else begin
                  beat <= beat + 1'b1;
                  tx_q <= bitmap[(int'(beat) + 1) * LANES +: LANES];
               end
            end
            S_RX_WAIT: begin
               if (bus.rx_data[0]) begin
                  state <= S_RX_DATA;
                  beat  <= '0;
               end
            end
            S_RX_DATA: begin
               bitmap[int'(beat) * LANES +: LANES] <= bus.rx_data;
               if (last_beat) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            S_DRAIN: begin
               // Leave DRAIN on the same edge that clears the final bit so
               // addr_valid drops and done rises together.
               if (pop) begin
                  bitmap <= bitmap & ~low_hot;
                  if ((bitmap & ~low_hot) == '0) begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end
               end else if (bitmap == '0) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sparse_bitmap_serdes.sv
// ---------------------------------------------------------------------------
// tb_sparse_bitmap_serdes
// Directed bench for sparse_bitmap_serdes (SIZE=16, LANES=2). Instance A is
// the main device; instance B receives A's bitstream for loopback.
// ---------------------------------------------------------------------------
module tb_sparse_bitmap_serdes;
   localparam int SIZE  = 16;
   localparam int LANES = 2;

   localparam logic [2:0] NOP  = 3'd0;
   localparam logic [2:0] SET  = 3'd1;
   localparam logic [2:0] CLR  = 3'd2;
   localparam logic [2:0] TX   = 3'd3;
   localparam logic [2:0] RX   = 3'd4;
   localparam logic [2:0] DRN  = 3'd5;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   int   checks = 0;
   int   errors = 0;

   sparse_bitmap_serdes_if #(.SIZE(SIZE), .LANES(LANES)) a_if ();
   sparse_bitmap_serdes_if #(.SIZE(SIZE), .LANES(LANES)) b_if ();

   assign b_if.rx_data = a_if.tx_data;

   sparse_bitmap_serdes #(.SIZE(SIZE), .LANES(LANES)) dut_a (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (a_if)
   );

   sparse_bitmap_serdes #(.SIZE(SIZE), .LANES(LANES)) dut_b (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (b_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmd_a(input logic [2:0] o, input logic [3:0] a);
      a_if.op_valid = 1'b1;
      a_if.op       = o;
      a_if.addr_in  = a;
      tick();
      a_if.op_valid = 1'b0;
      a_if.op       = NOP;
   endtask

   task automatic cmd_b(input logic [2:0] o);
      b_if.op_valid = 1'b1;
      b_if.op       = o;
      tick();
      b_if.op_valid = 1'b0;
      b_if.op       = NOP;
   endtask

   logic [1:0] exp_beats [6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};

   initial begin
      reset           = 1'b1;
      enable          = 1'b0;
      a_if.op_valid   = 1'b0;
      a_if.op         = NOP;
      a_if.addr_in    = '0;
      a_if.addr_ready = 1'b0;
      a_if.rx_data    = '0;
      b_if.op_valid   = 1'b0;
      b_if.op         = NOP;
      b_if.addr_in    = '0;
      b_if.addr_ready = 1'b0;

      // 1. reset
      tick();
      tick();
      chk("rst_busy", a_if.busy, 0);
      chk("rst_tx", a_if.tx_data, 0);
      chk("rst_addr_valid", a_if.addr_valid, 0);
      chk("rst_addr_out", a_if.addr_out, 0);
      chk("rst_done", a_if.done, 0);
      chk("rst_op_ready_en0", a_if.op_ready, 0);
      enable = 1'b1;
      #1;
      chk("rst_op_ready_en1", a_if.op_ready, 1);
      reset = 1'b0;
      tick();

      // 2. SET then DRAIN, then TRANSMIT of the emptied bitmap
      cmd_a(SET, 4'd3);
      chk("set_done", a_if.done, 1);
      chk("set_idle", a_if.busy, 0);
      cmd_a(SET, 4'd9);
      cmd_a(SET, 4'd15);
      a_if.addr_ready = 1'b1;
      cmd_a(DRN, 4'd0);
      chk("drain_v0", a_if.addr_valid, 1);
      chk("drain_a0", a_if.addr_out, 3);
      tick();
      chk("drain_a1", a_if.addr_out, 9);
      tick();
      chk("drain_a2", a_if.addr_out, 15);
      tick();
      chk("drain_end_valid", a_if.addr_valid, 0);
      chk("drain_end_done", a_if.done, 1);
      chk("drain_end_busy", a_if.busy, 0);
      cmd_a(TX, 4'd0);
      chk("empty_tx_hdr", a_if.tx_data, 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("empty_tx_beat", a_if.tx_data, 0);
      end
      tick();
      chk("empty_tx_done", a_if.done, 1);

      // 3. TRANSMIT of {3, 9, 15}
      cmd_a(SET, 4'd3);
      cmd_a(SET, 4'd9);
      cmd_a(SET, 4'd15);
      cmd_a(TX, 4'd0);
      chk("tx_hdr", a_if.tx_data, 2'b01);
      chk("tx_busy", a_if.busy, 1);
      chk("tx_op_ready", a_if.op_ready, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("tx_beat", a_if.tx_data, (k == 1 || k == 4 || k == 7) ? 2'b10 : 2'b00);
         chk("tx_beat_nodone", a_if.done, 0);
      end
      tick();
      chk("tx_done", a_if.done, 1);
      chk("tx_idle_data", a_if.tx_data, 0);
      chk("tx_idle_busy", a_if.busy, 0);

      // 4. loopback A -> B of {0, 5, 14}
      cmd_a(CLR, 4'd0);
      chk("clr_done", a_if.done, 1);
      cmd_b(RX);
      chk("b_rx_wait_busy", b_if.busy, 1);
      cmd_a(SET, 4'd0);
      cmd_a(SET, 4'd5);
      cmd_a(SET, 4'd14);
      chk("b_still_waiting", b_if.busy, 1);
      cmd_a(TX, 4'd0);
      for (int k = 0; k < 8; k++) tick();
      chk("b_no_early_done", b_if.done, 0);
      tick();
      chk("loop_a_done", a_if.done, 1);
      chk("loop_b_done", b_if.done, 1);
      b_if.addr_ready = 1'b1;
      cmd_b(DRN);
      chk("b_drain_a0", b_if.addr_out, 0);
      chk("b_drain_v0", b_if.addr_valid, 1);
      tick();
      chk("b_drain_a1", b_if.addr_out, 5);
      tick();
      chk("b_drain_a2", b_if.addr_out, 14);
      tick();
      chk("b_drain_done", b_if.done, 1);
      chk("b_drain_valid_end", b_if.addr_valid, 0);

      // 5. DRAIN back-pressure with ignored commands
      cmd_a(CLR, 4'd0);
      cmd_a(SET, 4'd2);
      cmd_a(SET, 4'd7);
      a_if.addr_ready = 1'b0;
      cmd_a(DRN, 4'd0);
      a_if.op_valid = 1'b1;
      a_if.op       = SET;
      a_if.addr_in  = 4'd0;
      for (int c = 0; c < 3; c++) begin
         chk("bp_hold_addr", a_if.addr_out, 2);
         chk("bp_hold_valid", a_if.addr_valid, 1);
         chk("bp_op_ready", a_if.op_ready, 0);
         tick();
      end
      a_if.addr_ready = 1'b1;
      chk("bp_release_addr", a_if.addr_out, 2);
      tick();
      chk("bp_next_addr", a_if.addr_out, 7);
      a_if.op_valid = 1'b0;
      a_if.op       = NOP;
      tick();
      chk("bp_done", a_if.done, 1);
      chk("bp_valid_end", a_if.addr_valid, 0);
      cmd_a(DRN, 4'd0);
      chk("bp_ignored_set_done", a_if.done, 1);
      chk("bp_ignored_set_valid", a_if.addr_valid, 0);

      // 6a. reset during TX_DATA beat 3
      cmd_a(SET, 4'd3);
      cmd_a(SET, 4'd9);
      cmd_a(SET, 4'd15);
      cmd_a(TX, 4'd0);
      for (int k = 0; k < 4; k++) tick();
      chk("pre_rst_busy", a_if.busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_tx", a_if.tx_data, 0);
      chk("midrst_busy", a_if.busy, 0);
      chk("midrst_done", a_if.done, 0);
      cmd_a(DRN, 4'd0);
      chk("midrst_bitmap_empty_done", a_if.done, 1);
      chk("midrst_bitmap_empty_valid", a_if.addr_valid, 0);

      // 6b. enable low for 2 cycles mid-TX
      cmd_a(SET, 4'd3);
      cmd_a(SET, 4'd9);
      cmd_a(SET, 4'd15);
      cmd_a(TX, 4'd0);
      chk("stall_hdr", a_if.tx_data, 1);
      tick();
      chk("stall_beat0", a_if.tx_data, 0);
      tick();
      chk("stall_beat1", a_if.tx_data, 2'b10);
      enable = 1'b0;
      tick();
      chk("stall_hold1", a_if.tx_data, 2'b10);
      tick();
      chk("stall_hold2", a_if.tx_data, 2'b10);
      chk("stall_busy", a_if.busy, 1);
      enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("stall_beat", a_if.tx_data, exp_beats[k]);
         chk("stall_nodone", a_if.done, 0);
      end
      tick();
      chk("stall_done", a_if.done, 1);
      chk("stall_tx_zero", a_if.tx_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
